column_solver: RTL and testbench
================================

COLUMN_SOLVER -- requirements
Module: column_solver

Interface
REQ-001 Parameters, one per line (name, default, meaning). All SHALL be honoured:
  DATA_W  32  signed fixed-point word width
  FRAC_W  27  fractional bits (value 1.0 = 1<<FRAC_W)
  ROW_BITS  8  row index width; max rows = 2**ROW_BITS
REQ-002 Ports, one per line (name, direction, width, meaning). Clock is clk; reset is reset, asynchronous and active-low:
  clk  in  1  single clock
  reset  in  1  async active-low reset
  height  in  ROW_BITS  top row index; rows 0..height
  iters  in  16  sweeps per start; 0 treated as 1
  alpha  in  DATA_W  alpha*dt/dx^2 multiplier
  bnd_mode  in  1  0 = fixed boundary (bnd_value), 1 = insulated (mirror center)
  bnd_value  in  DATA_W  fixed top/bottom boundary value
  src_en  in  1  pin source row
  src_row  in  ROW_BITS  source row index
  src_value  in  DATA_W  value forced at source row
  load_we  in  1  init write strobe
  load_row  in  ROW_BITS  init write row
  load_data  in  DATA_W  init write data
  start  in  1  begin sweep sequence
  node_left, node_right  in  DATA_W  neighbour column values, same row
  node_center  out  DATA_W  this column's pre-update value of current row
  row_idx  out  ROW_BITS  current row
  node_valid  out  1  high in CMP state
  busy  out  1  high in any state except IDLE
  done  out  1  one-cycle pulse after final sweep

Function
REQ-003 Storage SHALL be two banks of 2**ROW_BITS x DATA_W with synchronous read; a bank-select bit picks the read bank; writes go to the other bank.
REQ-004 States: IDLE, PR_RD, PR_WT, RD, WT, CMP, DONE.
REQ-005 IDLE: load_we=1 SHALL write load_data to load_row of the read bank; load_we outside IDLE SHALL be ignored.
REQ-006 IDLE with start=1 SHALL latch height, iters, alpha, bnd_mode, bnd_value, src_* and go to PR_RD; start outside IDLE SHALL be ignored. Simultaneous load_we and start: the write completes before priming reads it.
REQ-007 PR_RD issues read of row 0; PR_WT waits; center register captures row 0 on exit from PR_WT; down register is loaded with the lower boundary; go to RD with row_idx=0.
REQ-008 Per row r: RD issues read of row r+1 (omitted if r=height); WT waits; CMP captures up, computes, writes, then down<=center, center<=up.
REQ-009 Boundaries: up at r=height and down at r=0 SHALL be bnd_value if bnd_mode=0, else center. height=0 SHALL apply both.
REQ-010 node_center SHALL equal the center register, stable for all three cycles of row r; node_left/node_right SHALL be sampled only in CMP.
REQ-011 u_next = center + ((alpha * (up+down+left+right-4*center)) >>> FRAC_W); Laplacian in DATA_W+3 bits, product full width, arithmetic shift, sum saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
REQ-012 If src_en and r=src_row, written value SHALL be src_value instead of u_next.
REQ-013 CMP at r=height: toggle bank select; if sweeps remain, go to PR_RD, else DONE. Otherwise row_idx+1, go to RD.
REQ-014 DONE asserts done for exactly one cycle, then IDLE.
REQ-015 Start-to-done latency: done high in cycle iters*(2+3*(height+1))+1 after the start cycle.

Reset
REQ-016 reset low SHALL immediately force IDLE, bank select 0, row_idx 0, center/up/down 0, node_center 0, node_valid 0, busy 0, done 0, from any state including mid-sweep; memory contents SHALL NOT be reset.
REQ-017 After reset release, a start SHALL run a complete sequence with no residual state.

Verification
REQ-018 Diffusion: FRAC_W=27, alpha=0x0200_0000, height=2, rows {0, 0x0800_0000, 0}, left=right=0, bnd_mode=0, bnd_value=0, iters=1 -> node_center sequence 0, 0x0800_0000, 0 over rows 0..2; next sweep reads 0x0200_0000, 0, 0x0200_0000; done in cycle 12.
REQ-019 Insulated: all rows and neighbours 0x0800_0000, bnd_mode=1, iters=3 -> all rows remain 0x0800_0000.
REQ-020 Saturation: alpha=0x0800_0000, center 0, up=down=left=right=0x7FFF_FFFF -> written 0x7FFF_FFFF; negated inputs -> 0x8000_0000.
REQ-021 Source pin: REQ-018 setup with src_en=1, src_row=1, src_value=0x4000_0000 -> row 1 reads 0x4000_0000 after each sweep.
REQ-022 Start pulsed while busy and load_we during sweep -> no restart, memory unchanged, done latency per REQ-015.
REQ-023 reset low during row 1 CMP -> busy=0, done=0, node_center=0 immediately; new start completes normally.

Source files
------------

// File: rtl/column_solver.sv
// column_solver
// Updates one column of a 2-D heat-diffusion grid, one row at a time, for a
// configurable number of sweeps. The column lives in two memory banks: a sweep
// reads the current values from one bank and writes the updated values to the
// other. The banks swap roles after every sweep.
// The column's left and right neighbour values are supplied externally, row by
// row. They are sampled while node_valid is high.
//
// Ports
//   clk, reset        single clock, asynchronous active-low reset
//   height            top row index; the column spans rows 0..height
//   iters             sweeps per start (0 runs one sweep)
//   alpha             alpha*dt/dx^2 multiplier, fixed point with FRAC_W fraction bits
//   bnd_mode          0: the boundary rows see bnd_value; 1: the boundary mirrors the center
//   bnd_value         value used beyond the top and bottom rows when bnd_mode=0
//   src_en/src_row/src_value  pins src_row to src_value on every write
//   load_we/load_row/load_data  initial-value write port (accepted in IDLE only)
//   start             begins a sweep sequence (accepted in IDLE only)
//   node_left/right   neighbour column values for the current row
//   node_center       pre-update value of the current row
//   row_idx           current row
//   node_valid        high in the cycle that samples the neighbours
//   busy / done       sequence in progress / one-cycle completion pulse
//
// state  | meaning
// IDLE   | accept loads and start
// PR_RD  | read of row 0 issued
// PR_WT  | row 0 returning; prime center and down
// RD     | read of row r+1 issued (skipped at the top row)
// WT     | row r+1 returning; capture up
// CMP    | compute and write row r; shift the window
// DONE   | done pulse
module column_solver #(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 27,
  parameter int ROW_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROW_BITS-1:0] height,
  input  logic [15:0]         iters,
  input  logic [DATA_W-1:0]   alpha,
  input  logic                bnd_mode,
  input  logic [DATA_W-1:0]   bnd_value,
  input  logic                src_en,
  input  logic [ROW_BITS-1:0] src_row,
  input  logic [DATA_W-1:0]   src_value,
  input  logic                load_we,
  input  logic [ROW_BITS-1:0] load_row,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                start,
  input  logic [DATA_W-1:0]   node_left,
  input  logic [DATA_W-1:0]   node_right,
  output logic [DATA_W-1:0]   node_center,
  output logic [ROW_BITS-1:0] row_idx,
  output logic                node_valid,
  output logic                busy,
  output logic                done
);

  localparam int DEPTH  = 2**ROW_BITS;
  localparam int LAP_W  = DATA_W + 3;
  localparam int PROD_W = DATA_W + LAP_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PR_RD = 3'd1;
  localparam logic [2:0] S_PR_WT = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WT    = 3'd4;
  localparam logic [2:0] S_CMP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]          state;
  logic                bsel;
  logic [ROW_BITS-1:0] row;
  logic [DATA_W-1:0]   center, up_q, down;
  logic [15:0]         iters_left;

  logic [ROW_BITS-1:0] h_q, src_row_q;
  logic [DATA_W-1:0]   alpha_q, bv_q, src_val_q;
  logic                mode_q, src_en_q;

  logic [DATA_W-1:0]   mem0 [DEPTH];
  logic [DATA_W-1:0]   mem1 [DEPTH];
  logic [DATA_W-1:0]   rd_data;

  logic                rd_en, we0, we1;
  logic [ROW_BITS-1:0] rd_addr, wa;
  logic [DATA_W-1:0]   wd, wr_value;
  logic                at_top;

  assign at_top = (row == h_q);

  // Update arithmetic
  logic signed [LAP_W-1:0]  up_x, dn_x, lf_x, rt_x, c_x, lap;
  logic signed [PROD_W-1:0] alpha_p, lap_p, c_p, prod, shifted, sum;
  logic [DATA_W-1:0]        u_next;

  always_comb begin
    up_x    = {{3{up_q[DATA_W-1]}}, up_q};
    dn_x    = {{3{down[DATA_W-1]}}, down};
    lf_x    = {{3{node_left[DATA_W-1]}}, node_left};
    rt_x    = {{3{node_right[DATA_W-1]}}, node_right};
    c_x     = {{3{center[DATA_W-1]}}, center};
    lap     = up_x + dn_x + lf_x + rt_x - (c_x <<< 2);
    alpha_p = {{(PROD_W-DATA_W){alpha_q[DATA_W-1]}}, alpha_q};
    lap_p   = {{(PROD_W-LAP_W){lap[LAP_W-1]}}, lap};
    c_p     = {{(PROD_W-DATA_W){center[DATA_W-1]}}, center};
    prod    = alpha_p * lap_p;
    shifted = prod >>> FRAC_W;
    sum     = shifted + c_p;
    if (sum > SAT_MAX)      u_next = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) u_next = SAT_MIN[DATA_W-1:0];
    else                    u_next = sum[DATA_W-1:0];
    wr_value = (src_en_q && (row == src_row_q)) ? src_val_q : u_next;
  end

  // Memory port control. Loads go to the read bank; sweep writes go to the other bank.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == S_PR_RD) begin
      rd_en = 1'b1;
    end else if (state == S_RD && !at_top) begin
      rd_en   = 1'b1;
      rd_addr = row + ROW_BITS'(1);
    end
    we0 = 1'b0;
    we1 = 1'b0;
    wa  = load_row;
    wd  = load_data;
    if (state == S_IDLE && load_we) begin
      we0 = ~bsel;
      we1 = bsel;
    end else if (state == S_CMP) begin
      wa  = row;
      wd  = wr_value;
      we0 = bsel;
      we1 = ~bsel;
    end
  end

  // The memory has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (we0) mem0[wa] <= wd;
    if (we1) mem1[wa] <= wd;
    if (rd_en) rd_data <= bsel ? mem1[rd_addr] : mem0[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bsel       <= 1'b0;
      row        <= '0;
      center     <= '0;
      up_q       <= '0;
      down       <= '0;
      iters_left <= '0;
      h_q        <= '0;
      src_row_q  <= '0;
      alpha_q    <= '0;
      bv_q       <= '0;
      src_val_q  <= '0;
      mode_q     <= 1'b0;
      src_en_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            h_q        <= height;
            iters_left <= (iters == 16'd0) ? 16'd1 : iters;
            alpha_q    <= alpha;
            mode_q     <= bnd_mode;
            bv_q       <= bnd_value;
            src_en_q   <= src_en;
            src_row_q  <= src_row;
            src_val_q  <= src_value;
            row        <= '0;
            state      <= S_PR_RD;
          end
        end
        S_PR_RD: state <= S_PR_WT;
        S_PR_WT: begin
          center <= rd_data;
          // The lower boundary is fixed for the whole sweep. In insulated mode it is row 0 itself.
          down   <= mode_q ? rd_data : bv_q;
          row    <= '0;
          state  <= S_RD;
        end
        S_RD: state <= S_WT;
        S_WT: begin
          // No read was issued for the top row, so rd_data is stale there and the boundary is used instead.
          up_q  <= at_top ? (mode_q ? center : bv_q) : rd_data;
          state <= S_CMP;
        end
        S_CMP: begin
          down   <= center;
          center <= up_q;
          if (at_top) begin
            bsel       <= ~bsel;
            row        <= '0;
            iters_left <= iters_left - 16'd1;
            state      <= (iters_left == 16'd1) ? S_DONE : S_PR_RD;
          end else begin
            row   <= row + ROW_BITS'(1);
            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign node_center = center;
  assign row_idx     = row;
  assign node_valid  = (state == S_CMP);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_column_solver.sv
// Self-checking bench for column_solver. The directed vectors come from a table
// and are followed by a readback. A few multi-cycle sequences follow them:
// start and load during a sweep, and reset in the middle of a sweep. The run
// ends with randomized runs checked against an array-level model of the sweeps.
module tb_column_solver;
  localparam int FW = 27;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  height;
  logic [15:0] iters;
  logic [31:0] alpha, bnd_value, src_value, load_data;
  logic        bnd_mode, src_en, load_we, start;
  logic [7:0]  src_row, load_row, row_idx;
  logic [31:0] node_left, node_right, node_center;
  logic        node_valid, busy, done;

  logic [31:0] left_tab [256];
  logic [31:0] right_tab [256];
  logic [31:0] init_tab [256];
  logic [31:0] cap [256];

  assign node_left  = left_tab[row_idx];
  assign node_right = right_tab[row_idx];

  column_solver #(.DATA_W(32), .FRAC_W(FW), .ROW_BITS(8)) dut (
    .clk(clk), .reset(reset), .height(height), .iters(iters), .alpha(alpha),
    .bnd_mode(bnd_mode), .bnd_value(bnd_value), .src_en(src_en),
    .src_row(src_row), .src_value(src_value), .load_we(load_we),
    .load_row(load_row), .load_data(load_data), .start(start),
    .node_left(node_left), .node_right(node_right), .node_center(node_center),
    .row_idx(row_idx), .node_valid(node_valid), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed { int row; logic [31:0] c; } exp_t;
  exp_t exp_q[$];

  logic [31:0] mmem [2][256];
  int          msel;
  bit          mon_en;
  logic [31:0] prev1, prev2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor for the compute cycles. It checks the row and the center against
  // the model queue, and checks that the center holds over RD/WT/CMP.
  initial begin
    exp_t e;
    prev1 = '0;
    prev2 = '0;
    forever begin
      @(negedge clk);
      if (mon_en && node_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_cmp: got row %0d want no compute cycle", row_idx);
        end else begin
          e = exp_q.pop_front();
          check("row_idx", {24'd0, row_idx}, e.c == e.c ? e.row : 0);
          check("node_center", node_center, e.c);
          check("center_stable", {31'd0, (node_center == prev1) && (node_center == prev2)}, 32'd1);
          cap[row_idx] = node_center;
        end
      end
      prev2 = prev1;
      prev1 = node_center;
    end
  end

  function automatic logic [31:0] upd(input logic [31:0] c, u, d, l, r, a);
    logic signed [79:0] cw, uw, dw, lw, rw, aw, lap, p, s;
    cw = $signed(c); uw = $signed(u); dw = $signed(d);
    lw = $signed(l); rw = $signed(r); aw = $signed(a);
    lap = uw + dw + lw + rw - 4 * cw;
    p   = aw * lap;
    s   = cw + (p >>> FW);
    if (s > 80'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -80'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic model_run(input int h, input int it, input logic [31:0] a, input bit mode,
                           input logic [31:0] bv, input bit se, input int sr, input logic [31:0] sv);
    int n;
    logic [31:0] c, u, d, v;
    exp_t e;
    n = (it == 0) ? 1 : it;
    for (int s = 0; s < n; s++) begin
      for (int r = 0; r <= h; r++) begin
        c = mmem[msel][r];
        u = (r == h) ? (mode ? c : bv) : mmem[msel][r+1];
        d = (r == 0) ? (mode ? c : bv) : mmem[msel][r-1];
        e.row = r;
        e.c   = c;
        exp_q.push_back(e);
        v = (se && r == sr) ? sv : upd(c, u, d, left_tab[r], right_tab[r], a);
        mmem[1-msel][r] = v;
      end
      msel = 1 - msel;
    end
  endtask

  task automatic run(input int h, input int it, input logic [31:0] a, input bit mode,
                     input logic [31:0] bv, input bit se, input int sr, input logic [31:0] sv,
                     input bit do_load, input int exp_lat, input bit disturb, input bit abort);
    int n, lat;
    bit hit;
    hit = 1'b0;
    lat = (exp_lat > 0) ? exp_lat : (((it == 0) ? 1 : it) * (2 + 3 * (h + 1)) + 1);
    if (do_load) begin
      for (int r = 0; r < h; r++) begin
        @(posedge clk); #1;
        load_we = 1'b1; load_row = 8'(r); load_data = init_tab[r];
        mmem[msel][r] = init_tab[r];
      end
    end
    @(posedge clk); #1;
    // The last row is loaded in the same cycle as start.
    if (do_load) begin
      load_we = 1'b1; load_row = 8'(h); load_data = init_tab[h];
      mmem[msel][h] = init_tab[h];
    end else begin
      load_we = 1'b0;
    end
    height = 8'(h); iters = 16'(it); alpha = a; bnd_mode = mode; bnd_value = bv;
    src_en = se; src_row = 8'(sr); src_value = sv; start = 1'b1;
    model_run(h, it, a, mode, bv, se, sr, sv);
    @(posedge clk); #1;
    start = 1'b0; load_we = 1'b0; n = 1;
    while (!done && n < 4000) begin
      if (disturb && n == 5) begin
        start = 1'b1; height = 8'd0; iters = 16'd7;
        load_we = 1'b1; load_row = 8'd0; load_data = $urandom;
      end else begin
        start = 1'b0; load_we = 1'b0;
      end
      if (abort && node_valid && row_idx == 8'd1) begin
        hit = 1'b1;
        reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_center", node_center, 32'd0);
        check("rst_valid", {31'd0, node_valid}, 32'd0);
        check("rst_row", {24'd0, row_idx}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        msel = 0;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    if (abort) check("abort_reached", {31'd0, hit}, 32'd1);
    check("done_latency", n, lat);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic readback(input int h);
    for (int r = 0; r < 256; r++) cap[r] = 32'hDEAD_BEEF;
    run(h, 1, 32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0, -1, 1'b0, 1'b0);
  endtask

  typedef struct packed {
    int h; int it; logic [31:0] a; bit mode; logic [31:0] bv;
    bit se; int sr; logic [31:0] sv;
    logic [2:0][31:0] init; logic [31:0] nb; int lat; logic [2:0][31:0] expv;
  } vec_t;

  function automatic vec_t mk(input int h, input int it, input logic [31:0] a, input bit mode,
                              input logic [31:0] bv, input bit se, input int sr, input logic [31:0] sv,
                              input logic [31:0] i0, i1, i2, nb, input int lat,
                              input logic [31:0] e0, e1, e2);
    vec_t v;
    v.h = h; v.it = it; v.a = a; v.mode = mode; v.bv = bv; v.se = se; v.sr = sr; v.sv = sv;
    v.init[0] = i0; v.init[1] = i1; v.init[2] = i2; v.nb = nb; v.lat = lat;
    v.expv[0] = e0; v.expv[1] = e1; v.expv[2] = e2;
    return v;
  endfunction

  vec_t vecs [6];

  task automatic setup_vec(input int i);
    for (int r = 0; r < 3; r++) init_tab[r] = vecs[i].init[r];
    for (int r = 0; r < 8; r++) begin
      left_tab[r]  = vecs[i].nb;
      right_tab[r] = vecs[i].nb;
    end
  endtask

  task automatic run_vec(input int i, input bit disturb, input bit abort);
    setup_vec(i);
    run(vecs[i].h, vecs[i].it, vecs[i].a, vecs[i].mode, vecs[i].bv, vecs[i].se, vecs[i].sr,
        vecs[i].sv, 1'b1, vecs[i].lat, disturb, abort);
  endtask

  task automatic check_vec(input int i);
    readback(vecs[i].h);
    for (int r = 0; r <= vecs[i].h; r++) check("table_row", cap[r], vecs[i].expv[r]);
  endtask

  initial begin
    int h, it, ai;
    vecs[0] = mk(2, 1, 32'h0200_0000, 1'b0, 32'h0, 1'b0, 0, 32'h0,
                 32'h0, 32'h0800_0000, 32'h0, 32'h0, 12,
                 32'h0200_0000, 32'h0, 32'h0200_0000);
    vecs[1] = mk(2, 3, 32'h0200_0000, 1'b1, 32'h0, 1'b0, 0, 32'h0,
                 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 34,
                 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
    vecs[2] = mk(0, 1, 32'h0800_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 6,
                 32'h7FFF_FFFF, 32'h0, 32'h0);
    vecs[3] = mk(0, 1, 32'h0800_0000, 1'b0, 32'h8000_0001, 1'b0, 0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h8000_0001, 6,
                 32'h8000_0000, 32'h0, 32'h0);
    vecs[4] = mk(2, 2, 32'h0200_0000, 1'b0, 32'h0, 1'b1, 1, 32'h4000_0000,
                 32'h0, 32'h0800_0000, 32'h0, 32'h0, 23,
                 32'h1000_0000, 32'h4000_0000, 32'h1000_0000);
    vecs[5] = mk(1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0,
                 32'd5, 32'd7, 32'h0, 32'h0, 9,
                 32'd5, 32'd7, 32'h0);

    for (int r = 0; r < 256; r++) begin
      left_tab[r] = '0; right_tab[r] = '0; init_tab[r] = '0; cap[r] = '0;
      mmem[0][r] = '0; mmem[1][r] = '0;
    end
    msel = 0; mon_en = 1'b0;
    reset = 1'b0; height = '0; iters = '0; alpha = '0; bnd_mode = 1'b0; bnd_value = '0;
    src_en = 1'b0; src_row = '0; src_value = '0; load_we = 1'b0; load_row = '0;
    load_data = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_valid", {31'd0, node_valid}, 32'd0);
    check("reset_center", node_center, 32'd0);
    check("reset_row", {24'd0, row_idx}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(i, 1'b0, 1'b0);
      check_vec(i);
    end

    // Start and load during a sweep must be ignored.
    run_vec(0, 1'b1, 1'b0);
    check_vec(0);

    // Reset in the middle of a sweep, then a clean rerun.
    run_vec(4, 1'b0, 1'b1);
    run_vec(0, 1'b0, 1'b0);
    check_vec(0);

    for (int k = 0; k < 20; k++) begin
      h  = int'($urandom_range(0, 7));
      it = int'($urandom_range(0, 3));
      ai = int'($urandom_range(0, 32'h1000_0000)) - 32'h0800_0000;
      for (int r = 0; r <= h; r++) begin
        init_tab[r]  = (k < 10) ? ($urandom >> 3) - 32'h1000_0000 : $urandom;
        left_tab[r]  = (k < 10) ? ($urandom >> 3) - 32'h1000_0000 : $urandom;
        right_tab[r] = (k < 10) ? ($urandom >> 3) - 32'h1000_0000 : $urandom;
      end
      run(h, it, ai, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, h)), $urandom, 1'b1, -1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
